// File: rtl/sipo_load_ctrl.sv
// rtl/sipo_load_ctrl.sv - serial-to-parallel frame collector with valid/ready output register
//
// Purpose: collects WIDTH serial bits per frame (MSB first) while in SHIFT,
// loads the completed word into a parallel output register and holds it under
// a valid/ready handshake. A completed word that cannot be loaded because the
// output is still occupied is dropped and recorded in a sticky overrun flag.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   frame_start  starts (or restarts) a frame
//   sin          serial data bit
//   sin_valid    qualifies sin; only consumed in SHIFT
//   dout         parallel output word
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout when dout_valid=1
//   busy         high while in SHIFT
//   bit_cnt      bits captured in the current frame
//   overrun      sticky: a completed word was dropped
//   ovr_clr      clears overrun
module sipo_load_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state;
  // Only WIDTH-1 bits are stored: the final bit comes straight from sin on
  // the completion cycle.
  logic [WIDTH-2:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic             w_xfer;

  assign w_word     = {r_shreg, sin};
  // A restart on the completion cycle discards the completing bit, so
  // frame_start masks completion entirely.
  assign w_complete = (r_state == SHIFT) && sin_valid && !frame_start &&
                      (r_bit_cnt == LAST_IDX);
  // The output slot is free if empty or being emptied this same cycle.
  assign w_load     = w_complete && (!r_dout_valid || dout_ready);
  assign w_drop     = w_complete && r_dout_valid && !dout_ready;
  assign w_xfer     = r_dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state   <= SHIFT;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
          end else if (sin_valid) begin
            r_shreg <= w_word[WIDTH-2:0];
            if (r_bit_cnt == LAST_IDX) begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (w_xfer) begin
        r_dout_valid <= 1'b0;
      end

      // A drop in the same cycle as ovr_clr keeps the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign busy       = (r_state == SHIFT);
  assign bit_cnt    = r_bit_cnt;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// tb/tb_sipo_load_ctrl.sv - self-checking bench for sipo_load_ctrl
module tb_sipo_load_ctrl;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          frame_start;
  logic          sin;
  logic          sin_valid;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          ovr_clr;

  sipo_load_ctrl #(.WIDTH(W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .bit_cnt     (bit_cnt),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: frame membership plus the list of bits gathered so far.
  bit     m_in_frame;
  int     m_bits[$];
  int     m_dout;
  bit     m_dv;
  bit     m_ovr;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit fs, input bit s, input bit sv,
                            input bit rdy, input bit clr);
    bit loaded;
    bit dropped;
    int word;
    loaded  = 0;
    dropped = 0;
    if (rst) begin
      m_in_frame = 0;
      m_bits.delete();
      m_dout = 0;
      m_dv   = 0;
      m_ovr  = 0;
    end else begin
      if (fs) begin
        m_in_frame = 1;
        m_bits.delete();
      end else if (m_in_frame && sv) begin
        m_bits.push_back(int'(s));
        if (m_bits.size() == W) begin
          word = 0;
          for (int i = 0; i < W; i++) word += m_bits[i] * (1 << (W - 1 - i));
          m_bits.delete();
          m_in_frame = 0;
          if (!m_dv || rdy) begin
            m_dout = word;
            loaded = 1;
          end else begin
            dropped = 1;
          end
        end
      end
      if (loaded) m_dv = 1;
      else if (m_dv && rdy) m_dv = 0;
      if (dropped) m_ovr = 1;
      else if (clr) m_ovr = 0;
    end
  endtask

  // One clock: drive inputs, advance the model, sample after the edge, compare.
  task automatic step(input bit rst, input bit fs, input bit s, input bit sv,
                      input bit rdy, input bit clr);
    reset       = rst;
    frame_start = fs;
    sin         = s;
    sin_valid   = sv;
    dout_ready  = rdy;
    ovr_clr     = clr;
    model_edge(rst, fs, s, sv, rdy, clr);
    @(posedge clk);
    #1;
    cyc++;
    chk("dout",       int'(dout),       m_dout);
    chk("dout_valid", int'(dout_valid), int'(m_dv));
    chk("busy",       int'(busy),       int'(m_in_frame));
    chk("bit_cnt",    int'(bit_cnt),    m_bits.size());
    chk("overrun",    int'(overrun),    int'(m_ovr));
  endtask

  task automatic send_bits(input logic [W-1:0] w, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) step(0, 0, w[i], 1, (i == 0) ? rdy_last : 1'b0, 0);
  endtask

  initial begin
    logic [W-1:0] pat;
    reset = 1; frame_start = 0; sin = 0; sin_valid = 0; dout_ready = 0; ovr_clr = 0;
    m_in_frame = 0; m_dout = 0; m_dv = 0; m_ovr = 0;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dv", int'(dout_valid), 0);

    // back-to-back frame 1011
    step(0, 1, 0, 0, 0, 0);
    chk("tp1_busy", int'(busy), 1);
    pat = 4'b1011;
    send_bits(pat, 0);
    chk("tp1_dout", int'(dout), 4'hB);
    chk("tp1_dv", int'(dout_valid), 1);
    chk("tp1_busy_fall", int'(busy), 0);
    step(0, 0, 0, 0, 1, 0);

    // same frame with 3-cycle gaps; bit_cnt holds across gaps
    step(0, 1, 0, 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      step(0, 0, pat[i], 1, 0, 0);
      if (i != 0) chk("tp2_cnt", int'(bit_cnt), W - i);
      for (int g = 0; g < 3; g++) step(0, 0, 1'($urandom), 0, 0, 0);
      if (i != 0) chk("tp2_cnt_hold", int'(bit_cnt), W - i);
    end
    chk("tp2_dout", int'(dout), 4'hB);

    // overrun: dout held, second word dropped
    step(0, 1, 0, 0, 0, 0);
    pat = 4'b0110;
    send_bits(pat, 0);
    chk("tp3_dout_kept", int'(dout), 4'hB);
    chk("tp3_ovr", int'(overrun), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("tp3_ovr_clr", int'(overrun), 0);

    // load coincides with transfer
    step(0, 1, 0, 0, 0, 0);
    send_bits(pat, 1);
    chk("tp4_dout", int'(dout), 4'h6);
    chk("tp4_dv", int'(dout_valid), 1);
    chk("tp4_ovr", int'(overrun), 0);
    step(0, 0, 0, 0, 1, 0);

    // restart mid-frame discards earlier bits
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    chk("tp5_restart_cnt", int'(bit_cnt), 0);
    pat = 4'b0010;
    send_bits(pat, 0);
    chk("tp5_dout", int'(dout), 4'h2);
    chk("tp5_ovr", int'(overrun), 0);

    // reset mid-frame with a held word, then bits without frame_start
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    chk("tp6_dout", int'(dout), 0);
    chk("tp6_dv", int'(dout_valid), 0);
    chk("tp6_busy", int'(busy), 0);
    chk("tp6_cnt", int'(bit_cnt), 0);
    for (int i = 0; i < 2 * W; i++) step(0, 0, 1, 1, 0, 0);
    chk("tp6_ignored_dv", int'(dout_valid), 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 11) == 0),
           1'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_load_ctrl.md
Name: sipo_load_ctrl

Overview:
Controller that sequences a serial-to-parallel transfer into a WIDTH-bit parallel output register. It collects WIDTH serial bits per frame, MSB first, and loads the completed word into the output register in one cycle. It presents that word downstream with a valid/ready handshake. It sits between a serial source (bit stream plus valid qualifier) and the parallel consumers of the Serial-Parallel register blocks.

Parameters:
WIDTH, 4, word width in bits (≥2)
CW, 3, bit-counter width; must satisfy 2**CW > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
frame_start  input  1  starts a new frame (pulse)
sin  input  1  serial data bit
sin_valid  input  1  sin qualifier; bit consumed only in SHIFT state
dout  output  WIDTH  parallel word (output register)
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid=1
busy  output  1  high while in SHIFT state
bit_cnt  output  CW  bits captured in current frame
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  clears overrun

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, shift register=0, bit_cnt=0, dout=0, dout_valid=0, busy=0, overrun=0. Reset mid-frame discards the partial word and any held dout.
- FSM states: IDLE, SHIFT. busy = (state==SHIFT), decoded from the registered state.
- IDLE:
  - sin and sin_valid are ignored.
  - frame_start=1 → next cycle SHIFT, bit_cnt=0, shift register=0.
- SHIFT:
  - Each cycle with sin_valid=1: shreg ← {shreg[WIDTH-2:0], sin}, bit_cnt ← bit_cnt+1.
  - Cycles with sin_valid=0 hold all state; gaps are unlimited.
- Word completion: a cycle in SHIFT with sin_valid=1 and bit_cnt==WIDTH-1.
  - The completed word is {shreg[WIDTH-2:0], sin}.
  - Next state IDLE, bit_cnt ← 0.
  - Load rule: the word is written to dout if dout_valid=0, or if dout_valid=1 and dout_ready=1 in the same cycle. dout_valid is then 1 the following cycle.
  - Latency: last bit sampled at edge N → dout/dout_valid visible after edge N (one registered stage).
  - Otherwise (dout_valid=1, dout_ready=0): the word is dropped, dout is unchanged, overrun ← 1.
- frame_start while in SHIFT (including the completion cycle): restart takes priority. bit_cnt ← 0, shreg ← 0, stay in SHIFT, and the in-flight or completing bit is discarded. No flag is raised and overrun is not set.
- Handshake:
  - dout_valid stays 1 and dout stays stable until a cycle with dout_ready=1.
  - That cycle is a transfer; dout_valid then falls unless a new word loads the same cycle.
  - With dout_valid=0, dout_ready is ignored.
- overrun:
  - Set only by a dropped word; stays set until ovr_clr=1 or reset.
  - If ovr_clr and a new drop occur in the same cycle, the set wins and overrun stays 1.
- bit_cnt never exceeds WIDTH-1; no wrap-around beyond completion.

Test Plan:
- Reset, then frame_start; sin_valid=1 with sin=1,0,1,1 on 4 consecutive cycles, dout_ready=0 → dout=4'b1011 and dout_valid=1 one cycle after the 4th bit; busy falls the same cycle; bit_cnt=0.
- Same frame with sin_valid=0 gaps of 3 cycles between bits → identical dout=4'b1011; bit_cnt steps 1,2,3 and holds during gaps.
- dout_valid=1 holding 4'b1011, dout_ready=0; second frame sin=0,1,1,0 → dout stays 4'b1011, overrun=1. Assert ovr_clr → overrun=0 next cycle.
- dout_valid=1 holding 4'b1011; second frame completes with 0,1,1,0 while dout_ready=1 on the completion cycle → dout=4'b0110, dout_valid stays 1, overrun=0.
- frame_start after 2 bits (1,1), then bits 0,0,1,0 → dout=4'b0010, not containing the aborted bits; no overrun.
- Reset asserted after 3 bits of a frame, with dout_valid=1 → next cycle all outputs 0, state IDLE. Bits sent without frame_start are ignored (dout_valid stays 0).
